// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: takes an execute-stage result and performs
// big-endian byte/half/word loads and stores over a req/ack memory port,
// with a bounded wait. The result goes to writeback over valid/ready.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic [3:0]  in_mem_op,
    input  logic [4:0]  in_dest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_dest,
    output logic        out_we,
    output logic [1:0]  out_exc
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_dest_q, out_dest_d;
    logic        out_we_q, out_we_d;
    logic [1:0]  out_exc_q, out_exc_d;

    logic in_load, in_store, in_byte, in_half, in_word, in_misal;
    logic accept, timeout;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;

    // Decode the incoming op code; unknown codes fall through as none-ops.
    always_comb begin
        in_load  = 1'b0;
        in_store = 1'b0;
        in_byte  = 1'b0;
        in_half  = 1'b0;
        in_word  = 1'b0;
        case (in_mem_op)
            4'b0001, 4'b0010: begin in_load = 1'b1;  in_byte = 1'b1; end
            4'b0011, 4'b0100: begin in_load = 1'b1;  in_half = 1'b1; end
            4'b0101:          begin in_load = 1'b1;  in_word = 1'b1; end
            4'b1001:          begin in_store = 1'b1; in_byte = 1'b1; end
            4'b1010:          begin in_store = 1'b1; in_half = 1'b1; end
            4'b1011:          begin in_store = 1'b1; in_word = 1'b1; end
            default: ;
        endcase
        in_misal = (in_half && in_result[0]) || (in_word && (in_result[1:0] != 2'b00));
    end

    assign accept  = in_valid && in_ready;
    // An ack in the last allowed cycle wins over the timeout.
    assign timeout = (state_q == StAccess) && !mem_ack && (wait_q == WaitLast);

    // Extract and extend the addressed lanes of the read word (offset 0 = MSB lane).
    always_comb begin
        byte_val = 8'(mem_rdata >> {~addr_q[1:0], 3'b000});
        half_val = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (op_q)
            4'b0001: load_val = {{24{byte_val[7]}}, byte_val};
            4'b0010: load_val = {24'h000000, byte_val};
            4'b0011: load_val = {{16{half_val[15]}}, half_val};
            4'b0100: load_val = {16'h0000, half_val};
            default: load_val = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RESP can hand straight over to a newly accepted op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StResp: begin
                if (state_q == StResp && out_ready) state_d = StIdle;
                if (accept) begin
                    state_d = ((in_load || in_store) && !in_misal) ? StAccess : StResp;
                end
            end
            StAccess: begin
                if (mem_ack || timeout) state_d = StResp;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; memory-port fields are forced to zero outside ACCESS.
    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StResp) && out_ready);
        mem_req   = (state_q == StAccess);
        mem_we    = mem_req && we_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = mem_req ? be_q : 4'h0;
        mem_wdata = mem_req ? wdata_q : 32'h0;
        out_valid = (state_q == StResp);
        out_data  = out_valid ? out_data_q : 32'h0;
        out_dest  = out_valid ? out_dest_q : 5'h0;
        out_we    = out_valid && out_we_q;
        out_exc   = out_valid ? out_exc_q : 2'b00;
    end

    // Datapath next-state: capture on accept, complete on ack or timeout.
    always_comb begin
        op_d       = op_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        out_we_d   = out_we_q;
        out_exc_d  = out_exc_q;
        if (accept) begin
            op_d       = in_mem_op;
            addr_d     = in_result;
            out_dest_d = in_dest;
            we_d       = in_store;
            wait_d     = 8'h00;
            out_exc_d  = 2'b00;
            if (in_byte)      be_d = 4'b1000 >> in_result[1:0];
            else if (in_half) be_d = in_result[1] ? 4'b0011 : 4'b1100;
            else              be_d = 4'b1111;
            if (in_byte)      wdata_d = {4{in_store_data[7:0]}};
            else if (in_half) wdata_d = {2{in_store_data[15:0]}};
            else              wdata_d = in_store_data;
            if (!(in_load || in_store)) begin
                out_data_d = in_result;
                out_we_d   = 1'b1;
            end else if (in_misal) begin
                out_data_d = in_result;
                out_we_d   = 1'b0;
                out_exc_d  = 2'b01;
            end else begin
                out_data_d = 32'h0;
                out_we_d   = 1'b0;
            end
        end else if (state_q == StAccess) begin
            if (mem_ack) begin
                out_data_d = we_q ? 32'h0 : load_val;
                out_we_d   = !we_q;
                out_exc_d  = 2'b00;
            end else if (timeout) begin
                out_data_d = addr_q;
                out_we_d   = 1'b0;
                out_exc_d  = 2'b10;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= 4'h0;
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            wait_q     <= 8'h00;
            out_data_q <= 32'h0;
            out_dest_q <= 5'h0;
            out_we_q   <= 1'b0;
            out_exc_q  <= 2'b00;
        end else begin
            op_q       <= op_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
            out_we_q   <= out_we_d;
            out_exc_q  <= out_exc_d;
        end
    end

endmodule
